// File: rtl/filter_mac.sv
// filter_mac: sequential FIR multiply-accumulate engine.
// One sample is accepted in IDLE, then NTAPS MAC cycles (one multiply per clock)
// produce a 40-bit signed sum delivered with a one-cycle valid strobe.
module filter_mac #(
    parameter int NTAPS = 16,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic signed [15:0]  din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic                rf_coeff_wr,
    input  logic [AW-1:0]       rf_coeff_addr,
    input  logic signed [15:0]  rf_coeff_data,
    input  logic                trig_mac_flag_clear,
    output logic signed [39:0]  acc_out,
    output logic                acc_valid,
    output logic                ro_sample_drop_flag,
    output logic                ro_coeff_wr_err_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
    localparam logic [AW:0]   NTAPS_W  = (AW + 1)'(NTAPS);

    state_t             state;
    logic signed [15:0] x [NTAPS];
    logic signed [15:0] c [NTAPS];
    logic signed [39:0] acc;
    logic [AW-1:0]      k;

    logic               accept;
    logic               coeff_we;
    logic signed [31:0] prod;
    logic signed [39:0] acc_sum;

    assign din_ready = (state == IDLE);
    assign accept    = (state == IDLE) && din_valid;
    assign coeff_we  = (state == IDLE) && rf_coeff_wr && ({1'b0, rf_coeff_addr} < NTAPS_W);

    // Current tap product, full 16x16 signed, and the running sum it feeds
    always_comb begin
        prod    = '0;
        acc_sum = '0;
        prod    = x[k] * c[k];
        acc_sum = acc + {{8{prod[31]}}, prod};
    end

    // Sample delay line: shifts only when a sample is accepted in IDLE
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                x[i] <= '0;
            end
        end else if (accept) begin
            for (int unsigned i = NTAPS - 1; i > 0; i--) begin
                x[i] <= x[i-1];
            end
            x[0] <= din;
        end
    end

    // Coefficient bank: writable only in IDLE, out-of-range addresses ignored
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                c[i] <= '0;
            end
        end else if (coeff_we) begin
            c[rf_coeff_addr] <= rf_coeff_data;
        end
    end

    // Control FSM with accumulator, tap index and registered result/strobe
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            acc       <= '0;
            k         <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    k   <= k + 1'b1;
                    if (k == LAST_TAP) begin
                        acc_out   <= acc_sum;
                        acc_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a clear in the same cycle overrides a new set event
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ro_sample_drop_flag  <= 1'b0;
            ro_coeff_wr_err_flag <= 1'b0;
        end else if (trig_mac_flag_clear) begin
            ro_sample_drop_flag  <= 1'b0;
            ro_coeff_wr_err_flag <= 1'b0;
        end else begin
            if ((state == MAC) && din_valid) begin
                ro_sample_drop_flag <= 1'b1;
            end
            if ((state == MAC) && rf_coeff_wr) begin
                ro_coeff_wr_err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_filter_mac.sv
// tb_filter_mac: directed self-checking bench for filter_mac (NTAPS=16).
module tb_filter_mac;

    logic               clk;
    logic               rstb;
    logic signed [15:0] din;
    logic               din_valid;
    logic               din_ready;
    logic               rf_coeff_wr;
    logic [3:0]         rf_coeff_addr;
    logic signed [15:0] rf_coeff_data;
    logic               trig_mac_flag_clear;
    logic signed [39:0] acc_out;
    logic               acc_valid;
    logic               ro_sample_drop_flag;
    logic               ro_coeff_wr_err_flag;

    int checks = 0;
    int errors = 0;

    filter_mac #(.NTAPS(16), .AW(4)) dut (
        .clk                  (clk),
        .rstb                 (rstb),
        .din                  (din),
        .din_valid            (din_valid),
        .din_ready            (din_ready),
        .rf_coeff_wr          (rf_coeff_wr),
        .rf_coeff_addr        (rf_coeff_addr),
        .rf_coeff_data        (rf_coeff_data),
        .trig_mac_flag_clear  (trig_mac_flag_clear),
        .acc_out              (acc_out),
        .acc_valid            (acc_valid),
        .ro_sample_drop_flag  (ro_sample_drop_flag),
        .ro_coeff_wr_err_flag (ro_coeff_wr_err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coeff(input logic [3:0] addr, input logic [15:0] data);
        rf_coeff_wr   = 1'b1;
        rf_coeff_addr = addr;
        rf_coeff_data = data;
        step();
        rf_coeff_wr   = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] d);
        din       = d;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // Waits for acc_valid (bounded); optionally pokes drop/write/clear at one step
    task automatic wait_result(input int poke_step, input logic poke_drop,
                               input logic poke_wr, input logic poke_clear,
                               output logic [39:0] res, output int lat,
                               output logic held, output logic ready_at_valid);
        logic [39:0] prev;
        prev = acc_out;
        held = 1'b1;
        ready_at_valid = 1'b0;
        lat = 0;
        res = '0;
        while (lat < 100) begin
            if (lat == poke_step) begin
                din_valid           = poke_drop;
                din                 = 16'sh0001;
                rf_coeff_wr         = poke_wr;
                rf_coeff_addr       = 4'd0;
                rf_coeff_data       = 16'sh0001;
                trig_mac_flag_clear = poke_clear;
            end
            step();
            din_valid           = 1'b0;
            rf_coeff_wr         = 1'b0;
            trig_mac_flag_clear = 1'b0;
            lat++;
            if (acc_valid === 1'b1) begin
                res = acc_out;
                ready_at_valid = din_ready;
                break;
            end
            if (acc_out !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [39:0] res;
        int          lat;
        logic        held, rdy;
        step();
        step();
        checks++;
        if (acc_out !== 40'd0 || acc_valid !== 1'b0 || din_ready !== 1'b1 ||
            ro_sample_drop_flag !== 1'b0 || ro_coeff_wr_err_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: acc_out=%h acc_valid=%b din_ready=%b drop=%b err=%b, required 0/0/1/0/0",
                     acc_out, acc_valid, din_ready, ro_sample_drop_flag, ro_coeff_wr_err_flag);
        end
        rstb = 1'b1;
        step();
        send_sample(16'sh1234);
        wait_result(-1, 1'b0, 1'b0, 1'b0, res, lat, held, rdy);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL zero_coeff_latency: got %0d cycles, required 16", lat);
        end
        checks++;
        if (res !== 40'd0) begin
            errors++;
            $display("FAIL zero_coeff_result: got %h, required 0000000000", res);
        end
        step();
        checks++;
        if (acc_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: acc_valid=%b, required 0", acc_valid);
        end
    endtask

    task automatic test_impulse();
        logic [39:0] res, expv;
        int          lat;
        logic        held, rdy;
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        step();
        for (int i = 0; i < 16; i++) write_coeff(4'(i), 16'(i + 1));
        // Back-to-back: each new sample is offered in the acc_valid cycle
        for (int n = 0; n < 16; n++) begin
            send_sample(n == 0 ? 16'sh7FFF : 16'sh0000);
            wait_result(-1, 1'b0, 1'b0, 1'b0, res, lat, held, rdy);
            expv = 40'(32767 * (n + 1));
            checks++;
            if (res !== expv || lat !== 16) begin
                errors++;
                $display("FAIL impulse_%0d: got %h after %0d cycles, required %h after 16",
                         n, res, lat, expv);
            end
            checks++;
            if (held !== 1'b1 || rdy !== 1'b1) begin
                errors++;
                $display("FAIL impulse_hold_ready_%0d: held=%b din_ready=%b, required 1/1",
                         n, held, rdy);
            end
        end
    endtask

    task automatic test_full_scale();
        logic [39:0] res, expv;
        int          lat;
        logic        held, rdy;
        for (int i = 0; i < 16; i++) write_coeff(4'(i), 16'sh8000);
        for (int n = 0; n < 16; n++) begin
            send_sample(16'sh8000);
            wait_result(-1, 1'b0, 1'b0, 1'b0, res, lat, held, rdy);
            expv = 40'(n + 1) << 30;
            checks++;
            if (res !== expv || lat !== 16) begin
                errors++;
                $display("FAIL full_scale_%0d: got %h after %0d cycles, required %h after 16",
                         n, res, lat, expv);
            end
        end
        checks++;
        if (acc_out !== 40'h04_0000_0000) begin
            errors++;
            $display("FAIL full_scale_final: got %h, required 0400000000", acc_out);
        end
    endtask

    task automatic test_sample_drop();
        logic [39:0] res;
        int          lat;
        logic        held, rdy;
        send_sample(16'sh8000);
        wait_result(2, 1'b1, 1'b0, 1'b0, res, lat, held, rdy);
        checks++;
        if (res !== 40'h04_0000_0000 || lat !== 16) begin
            errors++;
            $display("FAIL drop_result: got %h after %0d cycles, required 0400000000 after 16", res, lat);
        end
        checks++;
        if (ro_sample_drop_flag !== 1'b1) begin
            errors++;
            $display("FAIL drop_flag_set: got %b, required 1", ro_sample_drop_flag);
        end
        // The dropped sample must not have entered the delay line
        send_sample(16'sh8000);
        wait_result(-1, 1'b0, 1'b0, 1'b0, res, lat, held, rdy);
        checks++;
        if (res !== 40'h04_0000_0000) begin
            errors++;
            $display("FAIL drop_delay_line: got %h, required 0400000000", res);
        end
        trig_mac_flag_clear = 1'b1;
        step();
        trig_mac_flag_clear = 1'b0;
        checks++;
        if (ro_sample_drop_flag !== 1'b0) begin
            errors++;
            $display("FAIL drop_flag_clear: got %b, required 0", ro_sample_drop_flag);
        end
        send_sample(16'sh8000);
        wait_result(2, 1'b1, 1'b0, 1'b1, res, lat, held, rdy);
        checks++;
        if (ro_sample_drop_flag !== 1'b0 || res !== 40'h04_0000_0000) begin
            errors++;
            $display("FAIL drop_clear_wins: flag=%b result=%h, required 0 and 0400000000",
                     ro_sample_drop_flag, res);
        end
    endtask

    task automatic test_coeff_err();
        logic [39:0] res;
        int          lat;
        logic        held, rdy;
        send_sample(16'sh8000);
        wait_result(3, 1'b0, 1'b1, 1'b0, res, lat, held, rdy);
        checks++;
        if (ro_coeff_wr_err_flag !== 1'b1 || ro_sample_drop_flag !== 1'b0) begin
            errors++;
            $display("FAIL coeff_err_flag: err=%b drop=%b, required 1/0",
                     ro_coeff_wr_err_flag, ro_sample_drop_flag);
        end
        checks++;
        if (res !== 40'h04_0000_0000) begin
            errors++;
            $display("FAIL coeff_err_result: got %h, required 0400000000", res);
        end
        send_sample(16'sh8000);
        wait_result(-1, 1'b0, 1'b0, 1'b0, res, lat, held, rdy);
        checks++;
        if (res !== 40'h04_0000_0000) begin
            errors++;
            $display("FAIL coeff_err_old_c0: got %h, required 0400000000", res);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [39:0] res;
        int          lat;
        logic        held, rdy, saw_valid;
        send_sample(16'sh8000);
        step();
        step();
        step();
        step();
        rstb = 1'b0;
        #1;
        checks++;
        if (acc_out !== 40'd0 || acc_valid !== 1'b0 || din_ready !== 1'b1 ||
            ro_sample_drop_flag !== 1'b0 || ro_coeff_wr_err_flag !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: acc_out=%h acc_valid=%b din_ready=%b drop=%b err=%b, required 0/0/1/0/0",
                     acc_out, acc_valid, din_ready, ro_sample_drop_flag, ro_coeff_wr_err_flag);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (acc_valid !== 1'b0) saw_valid = 1'b1;
        end
        rstb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (acc_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_valid: acc_valid pulsed, required no pulse");
        end
        write_coeff(4'd0, 16'sh0001);
        write_coeff(4'd1, 16'sh0001);
        send_sample(16'sh0005);
        wait_result(-1, 1'b0, 1'b0, 1'b0, res, lat, held, rdy);
        checks++;
        if (res !== 40'd5 || lat !== 16) begin
            errors++;
            $display("FAIL midreset_clean_line: got %h after %0d cycles, required 0000000005 after 16",
                     res, lat);
        end
    endtask

    initial begin
        rstb                = 1'b0;
        din                 = '0;
        din_valid           = 1'b0;
        rf_coeff_wr         = 1'b0;
        rf_coeff_addr       = '0;
        rf_coeff_data       = '0;
        trig_mac_flag_clear = 1'b0;
        test_reset();
        test_impulse();
        test_full_scale();
        test_sample_drop();
        test_coeff_err();
        test_reset_mid_mac();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
